// File: rtl/fsc_pkg.sv
// Shared definitions for the frame-sync controller and its helpers.
//
// Contents:
//   fsc_state_e  - controller state encoding (HUNT / VERIFY / LOCKED, 2 bits)
//   FSC_PAT_W    - default sync word width
//   FSC_PATTERN  - default sync word, MSB received first
package fsc_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } fsc_state_e;

  localparam int unsigned FSC_PAT_W = 6;
  localparam logic [FSC_PAT_W-1:0] FSC_PATTERN = 6'b110110;

endpackage

// File: rtl/sync_window_match.sv
// Sliding-window pattern matcher for a serial bit stream.
//
// The last PAT_W-1 valid bits are kept in a shift register. The match output
// is combinational: it compares the stored bits plus the bit currently on
// bit_i against PATTERN, so a hit is visible on the same cycle as the final
// bit of the word. Overlapping occurrences are naturally detected.
//
// Ports:
//   clk_i    - rising-edge clock
//   rst_ni   - asynchronous active-low reset, clears the window
//   bit_i    - serial data bit
//   valid_i  - bit_i is shifted in only when high
//   match_o  - {window, bit_i} equals PATTERN
module sync_window_match
  import fsc_pkg::*;
#(
  parameter int unsigned          PAT_W   = FSC_PAT_W,
  parameter logic [PAT_W-1:0]     PATTERN = FSC_PATTERN
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic bit_i,
  input  logic valid_i,
  output logic match_o
);

  logic [PAT_W-2:0] win_q;
  logic [PAT_W-1:0] winExt;

  // The candidate word is the stored history with the newest bit appended;
  // its low PAT_W-1 bits are also the next window contents.
  assign winExt  = {win_q, bit_i};
  assign match_o = (winExt == PATTERN);

  // Window shift register, frozen while valid_i is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q <= '0;
    end else if (valid_i) begin
      win_q <= winExt[PAT_W-2:0];
    end
  end

endmodule

// File: rtl/frame_sync_controller.sv
// Serial frame-sync controller.
//
// Hunts the bit stream for the sync word, verifies it recurs every FRAME_BITS
// bits LOCK_CNT times, then declares lock. While locked it flywheels through
// up to MISS_LIMIT-1 consecutive missed sync words and drops back to hunting
// on the MISS_LIMIT-th. Payload bits of locked frames are emitted with their
// index for downstream deframing.
//
// Ports:
//   clk_i        - rising-edge clock
//   rst_ni       - asynchronous active-low reset
//   din_i        - serial data bit
//   din_valid_i  - din_i is sampled only when high; all state holds otherwise
//   locked_o     - high while in LOCKED
//   state_o      - current state (0 HUNT, 1 VERIFY, 2 LOCKED)
//   sync_pulse_o - one-cycle pulse, sync word accepted on the previous valid bit
//   sync_miss_o  - one-cycle pulse, expected sync slot did not match
//   pay_valid_o  - one-cycle pulse per payload bit (LOCKED only)
//   pay_bit_o    - payload bit, qualified by pay_valid_o
//   pay_idx_o    - payload bit index 0..PAY_LEN-1
// All outputs are registered.
module frame_sync_controller
  import fsc_pkg::*;
#(
  parameter int unsigned      PAT_W      = FSC_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN    = FSC_PATTERN,
  parameter int unsigned      PAY_LEN    = 10,
  parameter int unsigned      LOCK_CNT   = 3,
  parameter int unsigned      MISS_LIMIT = 3,
  localparam int unsigned     IDX_W      = (PAY_LEN > 1) ? $clog2(PAY_LEN) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             din_i,
  input  logic             din_valid_i,
  output logic             locked_o,
  output logic [1:0]       state_o,
  output logic             sync_pulse_o,
  output logic             sync_miss_o,
  output logic             pay_valid_o,
  output logic             pay_bit_o,
  output logic [IDX_W-1:0] pay_idx_o
);

  localparam int unsigned FRAME_BITS = PAT_W + PAY_LEN;
  localparam int unsigned POS_W      = $clog2(FRAME_BITS);
  localparam int unsigned HITS_W     = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W     = $clog2(MISS_LIMIT + 1);

  fsc_state_e        state_q,     state_d;
  logic [POS_W-1:0]  pos_q,       pos_d;
  logic [HITS_W-1:0] hits_q,      hits_d;
  logic [MISS_W-1:0] misses_q,    misses_d;
  logic              syncPulse_q, syncPulse_d;
  logic              syncMiss_q,  syncMiss_d;
  logic              locked_q,    locked_d;
  logic              payValid_q,  payValid_d;
  logic              payBit_q,    payBit_d;
  logic [IDX_W-1:0]  payIdx_q,    payIdx_d;

  logic              match;
  logic              atSyncEnd;
  logic [POS_W-1:0]  posNext;
  logic [HITS_W-1:0] hitsInc;
  logic [MISS_W-1:0] missesInc;

  sync_window_match #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_window (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .bit_i   (din_i),
    .valid_i (din_valid_i),
    .match_o (match)
  );

  // The last sync bit of a frame sits at FRAME_BITS-1; the frame counter wraps
  // there so the following bit is payload index 0.
  assign atSyncEnd = (pos_q == POS_W'(FRAME_BITS - 1));
  assign posNext   = atSyncEnd ? '0 : pos_q + POS_W'(1);
  assign hitsInc   = hits_q + HITS_W'(1);
  assign missesInc = misses_q + MISS_W'(1);

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= HUNT;
      pos_q       <= '0;
      hits_q      <= '0;
      misses_q    <= '0;
      syncPulse_q <= 1'b0;
      syncMiss_q  <= 1'b0;
      locked_q    <= 1'b0;
      payValid_q  <= 1'b0;
      payBit_q    <= 1'b0;
      payIdx_q    <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      hits_q      <= hits_d;
      misses_q    <= misses_d;
      syncPulse_q <= syncPulse_d;
      syncMiss_q  <= syncMiss_d;
      locked_q    <= locked_d;
      payValid_q  <= payValid_d;
      payBit_q    <= payBit_d;
      payIdx_q    <= payIdx_d;
    end
  end

  // Next-state logic. Outside HUNT the window is only consulted at the
  // expected sync end, so stray matches inside payload are ignored. A miss
  // that sends VERIFY back to HUNT consumes that bit; it is not re-examined
  // as a fresh HUNT candidate.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    hits_d      = hits_q;
    misses_d    = misses_q;
    syncPulse_d = 1'b0;
    syncMiss_d  = 1'b0;

    case (state_q)
      HUNT: begin
        if (din_valid_i && match) begin
          pos_d       = '0;
          hits_d      = HITS_W'(1);
          misses_d    = '0;
          syncPulse_d = 1'b1;
          state_d     = (LOCK_CNT == 1) ? LOCKED : VERIFY;
        end
      end

      VERIFY: begin
        if (din_valid_i) begin
          pos_d = posNext;
          if (atSyncEnd) begin
            if (match) begin
              hits_d      = hitsInc;
              syncPulse_d = 1'b1;
              if (hitsInc == HITS_W'(LOCK_CNT)) begin
                state_d = LOCKED;
              end
            end else begin
              state_d    = HUNT;
              hits_d     = '0;
              pos_d      = '0;
              syncMiss_d = 1'b1;
            end
          end
        end
      end

      LOCKED: begin
        if (din_valid_i) begin
          pos_d = posNext;
          if (atSyncEnd) begin
            if (match) begin
              misses_d    = '0;
              syncPulse_d = 1'b1;
            end else begin
              misses_d   = missesInc;
              syncMiss_d = 1'b1;
              if (missesInc == MISS_W'(MISS_LIMIT)) begin
                state_d = HUNT;
                hits_d  = '0;
                pos_d   = '0;
              end
            end
          end
        end
      end

      default: begin
        state_d  = HUNT;
        pos_d    = '0;
        hits_d   = '0;
        misses_d = '0;
      end
    endcase
  end

  // Registered output values. locked follows the next state so that it
  // changes on the same cycle as state_o.
  always_comb begin
    locked_d   = (state_d == LOCKED);
    payValid_d = din_valid_i && (state_q == LOCKED) && (pos_q < POS_W'(PAY_LEN));
    payBit_d   = din_valid_i ? din_i : payBit_q;
    payIdx_d   = din_valid_i ? IDX_W'(pos_q) : payIdx_q;
  end

  assign state_o      = state_q;
  assign locked_o     = locked_q;
  assign sync_pulse_o = syncPulse_q;
  assign sync_miss_o  = syncMiss_q;
  assign pay_valid_o  = payValid_q;
  assign pay_bit_o    = payBit_q;
  assign pay_idx_o    = payIdx_q;

endmodule

// File: tb/tb_frame_sync_controller.sv
// Directed testbench for frame_sync_controller (default parameters:
// sync word 110110, 10 payload bits, LOCK_CNT 3, MISS_LIMIT 3).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_frame_sync_controller;

  logic       clk = 1'b0;
  logic       rstN;
  logic       din;
  logic       dinValid;
  logic       locked;
  logic [1:0] state;
  logic       syncPulse;
  logic       syncMiss;
  logic       payValid;
  logic       payBit;
  logic [3:0] payIdx;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    logic       din;
    logic       valid;
    logic [1:0] expState;
    logic       expLocked;
    logic       expSync;
    logic       expMiss;
    logic       expPayValid;
    logic       expPayBit;
    logic [3:0] expPayIdx;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  frame_sync_controller dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .din_i        (din),
    .din_valid_i  (dinValid),
    .locked_o     (locked),
    .state_o      (state),
    .sync_pulse_o (syncPulse),
    .sync_miss_o  (syncMiss),
    .pay_valid_o  (payValid),
    .pay_bit_o    (payBit),
    .pay_idx_o    (payIdx)
  );

  // Drive one input cycle from a falling edge and return on the next one.
  task automatic applyStimulus(input logic d, input logic v);
    din      = d;
    dinValid = v;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [7:0] actual, input logic [7:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s (step %0d): actual=%0h expected=%0h", name, idx, actual, expected);
    end
  endtask

  task automatic pushVec(input logic d, input logic v, input logic [1:0] st,
                         input logic lk, input logic sy, input logic ms,
                         input logic pv, input logic pb, input logic [3:0] pi);
    vec_t t;
    t.din = d; t.valid = v; t.expState = st; t.expLocked = lk;
    t.expSync = sy; t.expMiss = ms; t.expPayValid = pv;
    t.expPayBit = pb; t.expPayIdx = pi;
    vecs.push_back(t);
  endtask

  // Six sync-slot bits: the first five expect the "during" state with no
  // pulses, the last expects the hand-computed end-of-slot result.
  task automatic pushSync(input logic [5:0] w, input logic [1:0] stDuring,
                          input logic lkDuring, input logic [1:0] stEnd,
                          input logic lkEnd, input logic sy, input logic ms);
    for (int i = 0; i < 5; i++)
      pushVec(w[5-i], 1'b1, stDuring, lkDuring, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    pushVec(w[0], 1'b1, stEnd, lkEnd, sy, ms, 1'b0, 1'b0, 4'd0);
  endtask

  // Ten payload bits, MSB first; gapMask[i] inserts an idle cycle (din=1,
  // din_valid=0) before payload bit i.
  task automatic pushPayload(input logic [9:0] data, input logic [9:0] gapMask,
                             input logic [1:0] st, input logic lk, input logic pay);
    for (int i = 0; i < 10; i++) begin
      if (gapMask[i])
        pushVec(1'b1, 1'b0, st, lk, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      pushVec(data[9-i], 1'b1, st, lk, 1'b0, 1'b0, pay, data[9-i], 4'(i));
    end
  endtask

  task automatic runVectors();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].din, vecs[i].valid);
      checkOutput("state",      i, 8'(state),     8'(vecs[i].expState));
      checkOutput("locked",     i, 8'(locked),    8'(vecs[i].expLocked));
      checkOutput("sync_pulse", i, 8'(syncPulse), 8'(vecs[i].expSync));
      checkOutput("sync_miss",  i, 8'(syncMiss),  8'(vecs[i].expMiss));
      checkOutput("pay_valid",  i, 8'(payValid),  8'(vecs[i].expPayValid));
      if (vecs[i].expPayValid) begin
        checkOutput("pay_bit", i, 8'(payBit), 8'(vecs[i].expPayBit));
        checkOutput("pay_idx", i, 8'(payIdx), 8'(vecs[i].expPayIdx));
      end
    end
    vecs.delete();
  endtask

  task automatic checkAllClear(input int tag);
    checkOutput("rst_state",     tag, 8'(state),     8'd0);
    checkOutput("rst_locked",    tag, 8'(locked),    8'd0);
    checkOutput("rst_sync",      tag, 8'(syncPulse), 8'd0);
    checkOutput("rst_miss",      tag, 8'(syncMiss),  8'd0);
    checkOutput("rst_pay_valid", tag, 8'(payValid),  8'd0);
    checkOutput("rst_pay_bit",   tag, 8'(payBit),    8'd0);
    checkOutput("rst_pay_idx",   tag, 8'(payIdx),    8'd0);
  endtask

  initial begin
    rstN     = 1'b0;
    din      = 1'b0;
    dinValid = 1'b0;

    // Reset held with random data: everything stays cleared.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'b1);
      checkAllClear(i);
    end
    rstN = 1'b1;

    // Acquisition, locked payload with gaps, flywheel and loss of lock.
    pushVec(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    pushVec(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    pushVec(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    pushVec(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    pushSync(6'b110110, 2'd0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    pushPayload(10'b0110100111, 10'b0001000000, 2'd1, 1'b0, 1'b0);
    pushSync(6'b110110, 2'd1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    pushPayload(10'b1011001110, 10'b0000000000, 2'd1, 1'b0, 1'b0);
    pushSync(6'b110110, 2'd1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0);
    pushPayload(10'b1001110100, 10'b1000110000, 2'd2, 1'b1, 1'b1);
    pushSync(6'b110110, 2'd2, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    pushPayload(10'b0011011011, 10'b0000000000, 2'd2, 1'b1, 1'b1);
    pushSync(6'b000000, 2'd2, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1);
    pushPayload(10'b1111100000, 10'b0000000000, 2'd2, 1'b1, 1'b1);
    pushSync(6'b100110, 2'd2, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1);
    pushPayload(10'b0101010101, 10'b0000000000, 2'd2, 1'b1, 1'b1);
    pushSync(6'b110110, 2'd2, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    pushPayload(10'b1100110011, 10'b0000000000, 2'd2, 1'b1, 1'b1);
    pushSync(6'b000000, 2'd2, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1);
    pushPayload(10'b0000011111, 10'b0000000000, 2'd2, 1'b1, 1'b1);
    pushSync(6'b111111, 2'd2, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1);
    pushPayload(10'b1010010110, 10'b0000000000, 2'd2, 1'b1, 1'b1);
    pushSync(6'b000000, 2'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    runVectors();

    // Overlap is ignored in VERIFY, then a failed verification.
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    pushSync(6'b110110, 2'd0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    pushPayload(10'b1100000000, 10'b0000000000, 2'd1, 1'b0, 1'b0);
    pushSync(6'b000000, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      pushVec(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    runVectors();

    // Reacquire and stop mid-payload for an asynchronous reset.
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    pushSync(6'b110110, 2'd0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    pushPayload(10'b0000000000, 10'b0000000000, 2'd1, 1'b0, 1'b0);
    pushSync(6'b110110, 2'd1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    pushPayload(10'b1111111111, 10'b0000000000, 2'd1, 1'b0, 1'b0);
    pushSync(6'b110110, 2'd1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0);
    pushVec(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    pushVec(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
    pushVec(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2);
    pushVec(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
    runVectors();

    rstN = 1'b0;
    #1;
    checkAllClear(100);
    @(negedge clk);
    rstN = 1'b1;

    // Partial frame is discarded: the tail of a sync word alone is not a hit.
    pushSync(6'b011011, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    runVectors();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
